booth_r4_mult_seq: RTL and testbench
====================================

Name: booth_r4_mult_seq

Overview:
Parametrised sequential radix-4 (modified Booth) multiplier. It is the successor to the team's radix-2 sequential multiplier. It retires 2 multiplier bits per cycle and supports signed or unsigned operands, selected per operation. It uses the same start/busy/done handshake, so it drops into existing datapaths as a faster, width-generic replacement.

Parameters:
- WIDTH, 8: operand width in bits. Must be even and >= 4.
- ITER, WIDTH/2+1: radix-4 iterations per multiply. Derived; must not be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned. Sampled with start.
- a_in  in  WIDTH  multiplicand. Sampled with start.
- b_in  in  WIDTH  multiplier. Sampled with start.
- product  out  2*WIDTH  result register. Held until next completion.
- busy  out  1  high while an operation is in flight.
- done  out  1  single-cycle completion pulse.
- abort  in  1  present only when BOOTH_ABORT_EN is defined.

Behaviour:
- Reset (async, any state): state=IDLE; product=0, busy=0, done=0; all internal registers cleared. An in-flight operation is lost and produces no done.
- States: IDLE -> CALC -> FINISH -> IDLE.
- IDLE:
  - done<=0.
  - start=1: capture operands and mode; accumulator<=0; q_-1<=0; count<=0; busy<=1; go to CALC.
  - start=0: busy<=0.
- Operand extension to WIDTH+2 bits: sign-extend when signed_mode=1, zero-extend when 0. This gives an even-length multiplier with a correct top Booth group.
- CALC, one iteration per cycle, exactly ITER cycles:
  - Recode triplet {q[1],q[0],q_-1}:
    - 000, 111 -> +0
    - 001, 010 -> +M
    - 011 -> +2M
    - 100 -> -2M
    - 101, 110 -> -M
  - Add the selected term to the accumulator (WIDTH+3 bits, no overflow possible).
  - Arithmetic shift right by 2 across {acc, q, q_-1}; count++.
  - After ITER iterations go to FINISH.
- FINISH:
  - product <= low 2*WIDTH bits of the {acc, q} concatenation, equal to the exact product (signed or unsigned per the captured mode).
  - done<=1, busy<=0, state<=IDLE.
- Latency: start sampled at edge E0. busy is high after E0. product, done and busy=0 are all visible after edge E0+ITER+1 (6 cycles for WIDTH=8, 10 for WIDTH=16).
- done is high for exactly one cycle.
- Back-to-back: start may be high in the cycle done is high. It is accepted, and busy stays 0 only for that single IDLE cycle.
- start while busy: ignored, with no effect on the current operation.
- Operand or mode changes after capture: no effect.
- product changes only in FINISH (or on reset).

Optional Feature:
- Macro: BOOTH_ABORT_EN.
- Defined:
  - Adds the abort input.
  - abort=1 sampled in CALC or FINISH: state<=IDLE, busy<=0, done stays 0, product unchanged.
  - abort in IDLE: ignored.
  - abort and start both high in IDLE: start wins.
- Undefined: no abort port; every accepted operation completes.

Test Plan:
1. WIDTH=8, unsigned, a=255, b=255 -> product=0xFE01. done pulses once, 6 cycles after start. busy high for cycles 1-5.
2. WIDTH=8, signed:
   - a=-128, b=-128 -> 0x4000.
   - a=-1, b=127 -> 0xFF81.
   - a=0x80, b=0x01 in unsigned mode -> 0x0080.
3. Back-to-back: start held high across two operations (3*5=15, then 7*9=63) -> done pulses twice. product=0x000F, then 0x003F, with one IDLE cycle between.
4. Reset mid-CALC (3 cycles into 100*100) -> product=0, busy=0, done=0. No done follows; the next start of 2*3 yields 6.
5. WIDTH=16: unsigned 0xFFFF*0xFFFF -> 0xFFFE0001 after 10 cycles. Signed 0x8000*0x7FFF -> 0xC0008000.
6. BOOTH_ABORT_EN: abort pulsed in cycle 2 of CALC -> busy=0 next cycle, no done, product retains the prior value. A subsequent 12*12 completes with 144.

Source files
------------

// File: rtl/booth_r4_mult_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : booth_r4_mult_seq_if
// Purpose  : Handshake and operand bundle for booth_r4_mult_seq.
//            master : requester side (drives start, operands, mode, abort)
//            slave  : multiplier side (drives product, busy, done)
// Signals  : start, signed_mode, a_in[WIDTH], b_in[WIDTH],
//            product[2*WIDTH], busy, done,
//            abort (only when BOOTH_ABORT_EN is defined)
// Revision : 1.0 - initial release
// ============================================================================
interface booth_r4_mult_seq_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       a_in;
    logic [WIDTH-1:0]       b_in;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;
    logic                   done;
`ifdef BOOTH_ABORT_EN
    logic                   abort;

    modport master (output start, signed_mode, a_in, b_in, abort,
                    input  product, busy, done);
    modport slave  (input  start, signed_mode, a_in, b_in, abort,
                    output product, busy, done);
`else
    modport master (output start, signed_mode, a_in, b_in,
                    input  product, busy, done);
    modport slave  (input  start, signed_mode, a_in, b_in,
                    output product, busy, done);
`endif
endinterface
`default_nettype wire

// File: rtl/booth_r4_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_r4_mult_seq
// Purpose  : Sequential radix-4 (modified Booth) multiplier, signed or
//            unsigned per operation, two multiplier bits retired per cycle.
//            Latency: start sampled at edge E0, result/done at E0+ITER+1.
// Ports    : clk          rising-edge clock
//            rst          asynchronous active-high reset
//            bus (slave)  start/signed_mode/a_in/b_in in,
//                         product/busy/done out, abort in (optional)
// Params   : WIDTH  operand width, even and >= 4
//            ITER   WIDTH/2+1, derived - do not override
// Options  : BOOTH_ABORT_EN  adds the abort input (cancels CALC/FINISH)
// Revision : 1.0 - initial release
// ============================================================================
module booth_r4_mult_seq #(
    parameter int WIDTH = 8,
    parameter int ITER  = WIDTH / 2 + 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    booth_r4_mult_seq_if.slave bus
);
    // Operands carry two extension bits so the multiplier has an even bit
    // count and its top Booth group sees the true sign (or a zero for
    // unsigned). The accumulator needs one more bit to hold +/-2M.
    localparam int c_EXT   = WIDTH + 2;
    localparam int c_ACC   = WIDTH + 3;
    localparam int c_CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t               r_state,   w_state_nxt;
    logic [c_EXT-1:0]     r_m,       w_m_nxt;
    logic [c_ACC-1:0]     r_acc,     w_acc_nxt;
    logic [c_EXT-1:0]     r_q,       w_q_nxt;
    logic                 r_qm1,     w_qm1_nxt;
    logic [c_CNT_W-1:0]   r_cnt,     w_cnt_nxt;
    logic [2*WIDTH-1:0]   r_product, w_product_nxt;
    logic                 r_busy,    w_busy_nxt;
    logic                 r_done,    w_done_nxt;

    logic [c_EXT-1:0]     w_a_ext;
    logic [c_EXT-1:0]     w_b_ext;
    logic [c_ACC-1:0]     w_m1;
    logic [c_ACC-1:0]     w_m2;
    logic [c_ACC-1:0]     w_term;
    logic [c_ACC-1:0]     w_sum;

    // Signed mode sign-extends, unsigned mode zero-extends.
    assign w_a_ext = {{2{bus.signed_mode & bus.a_in[WIDTH-1]}}, bus.a_in};
    assign w_b_ext = {{2{bus.signed_mode & bus.b_in[WIDTH-1]}}, bus.b_in};

    assign w_m1 = {r_m[c_EXT-1], r_m};
    assign w_m2 = {r_m, 1'b0};

    // Booth recoding of {q[1], q[0], q[-1]}.
    always_comb begin
        w_term = '0;
        unique case ({r_q[1:0], r_qm1})
            3'b001, 3'b010: w_term = w_m1;
            3'b011:         w_term = w_m2;
            3'b100:         w_term = -w_m2;
            3'b101, 3'b110: w_term = -w_m1;
            default:        w_term = '0;
        endcase
    end

    assign w_sum = r_acc + w_term;

    always_comb begin
        w_state_nxt   = r_state;
        w_m_nxt       = r_m;
        w_acc_nxt     = r_acc;
        w_q_nxt       = r_q;
        w_qm1_nxt     = r_qm1;
        w_cnt_nxt     = r_cnt;
        w_product_nxt = r_product;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;

        unique case (r_state)
            S_IDLE: begin
                w_done_nxt = 1'b0;
                if (bus.start) begin
                    w_m_nxt     = w_a_ext;
                    w_q_nxt     = w_b_ext;
                    w_acc_nxt   = '0;
                    w_qm1_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_CALC;
                end else begin
                    w_busy_nxt  = 1'b0;
                end
            end
            S_CALC: begin
                // Arithmetic shift right by 2 across {acc, q, q_-1}.
                w_acc_nxt = {w_sum[c_ACC-1], w_sum[c_ACC-1], w_sum[c_ACC-1:2]};
                w_q_nxt   = {w_sum[1:0], r_q[c_EXT-1:2]};
                w_qm1_nxt = r_q[1];
                w_cnt_nxt = r_cnt + c_CNT_W'(1);
                if (r_cnt == c_CNT_W'(ITER - 1)) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                // Low 2*WIDTH bits of {acc, q}; q already holds WIDTH+2 of them.
                w_product_nxt = {r_acc[WIDTH-3:0], r_q};
                w_done_nxt    = 1'b1;
                w_busy_nxt    = 1'b0;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b0;
            end
        endcase

`ifdef BOOTH_ABORT_EN
        // Abort cancels anything in flight; in IDLE it is ignored so start wins.
        if (bus.abort && (r_state != S_IDLE)) begin
            w_state_nxt   = S_IDLE;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b0;
            w_product_nxt = r_product;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_m       <= w_m_nxt;
            r_acc     <= w_acc_nxt;
            r_q       <= w_q_nxt;
            r_qm1     <= w_qm1_nxt;
            r_cnt     <= w_cnt_nxt;
            r_product <= w_product_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.product = r_product;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_booth_r4_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_r4_mult_seq
// Purpose  : Self-checking bench for booth_r4_mult_seq at WIDTH=8 and 16.
//            Expected products are queued when an operation is driven and
//            compared when done is seen. Abort steps are compiled in when
//            BOOTH_ABORT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_r4_mult_seq;
    logic clk = 1'b0;
    logic rst;

    booth_r4_mult_seq_if #(.WIDTH(8))  bus8();
    booth_r4_mult_seq_if #(.WIDTH(16)) bus16();

    booth_r4_mult_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    booth_r4_mult_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] sb[$];

    function automatic logic [31:0] model(bit w16, logic [15:0] a, logic [15:0] b, bit sgn);
        longint      sa;
        longint      sbv;
        longint      p;
        logic [7:0]  a8;
        logic [7:0]  b8;
        a8 = a[7:0];
        b8 = b[7:0];
        if (w16) begin
            sa  = sgn ? longint'($signed(a)) : longint'({48'b0, a});
            sbv = sgn ? longint'($signed(b)) : longint'({48'b0, b});
            p   = sa * sbv;
            return p[31:0];
        end else begin
            sa  = sgn ? longint'($signed(a8)) : longint'({56'b0, a8});
            sbv = sgn ? longint'($signed(b8)) : longint'({56'b0, b8});
            p   = sa * sbv;
            return {16'b0, p[15:0]};
        end
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(bit w16, output logic d, output logic bz, output logic [31:0] p);
        if (w16) begin
            d = bus16.done; bz = bus16.busy; p = bus16.product;
        end else begin
            d = bus8.done;  bz = bus8.busy;  p = {16'b0, bus8.product};
        end
    endtask

    // Called #1 after an edge; start is sampled at the next edge (E0).
    // Returns #1 after E0 with operands scrambled to show they are latched.
    task automatic drive(bit w16, logic [15:0] a, logic [15:0] b, bit sgn,
                         logic [31:0] exp, bit push, bit hold);
        if (push) sb.push_back(exp);
        if (w16) begin
            bus16.a_in = a; bus16.b_in = b; bus16.signed_mode = sgn; bus16.start = 1'b1;
        end else begin
            bus8.a_in = a[7:0]; bus8.b_in = b[7:0]; bus8.signed_mode = sgn; bus8.start = 1'b1;
        end
        @(posedge clk); #1;
        if (w16) begin
            if (!hold) bus16.start = 1'b0;
            bus16.a_in = 16'($urandom); bus16.b_in = 16'($urandom); bus16.signed_mode = ~sgn;
        end else begin
            if (!hold) bus8.start = 1'b0;
            bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom); bus8.signed_mode = ~sgn;
        end
    endtask

    // Called #1 after E0; waits for done, checking latency, busy and product.
    task automatic await_done(bit w16, int lat, bit trailing, string tag);
        logic        d;
        logic        bz;
        logic [31:0] p;
        int          cyc;
        bit          seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < lat + 4) begin
            @(posedge clk); #1;
            cyc++;
            sample(w16, d, bz, p);
            if (d) seen = 1'b1;
            else if (cyc == 1 || cyc == lat - 1) check({tag, "_busy_inflight"}, 32'(bz), 32'd1);
        end
        check({tag, "_latency"}, seen ? cyc : 0, lat);
        if (seen) begin
            check({tag, "_busy_at_done"}, 32'(bz), 32'd0);
            if (sb.size() > 0) check({tag, "_product"}, p, sb.pop_front());
            else               check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end
        if (trailing) begin
            @(posedge clk); #1;
            sample(w16, d, bz, p);
            check({tag, "_done_single_pulse"}, 32'(d), 32'd0);
        end
    endtask

    task automatic no_done_for(bit w16, int n, string tag);
        logic        d;
        logic        bz;
        logic [31:0] p;
        bit          seen;
        seen = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            sample(w16, d, bz, p);
            if (d) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        bit          rs;

        rst = 1'b1;
        bus8.start = 1'b0;  bus8.signed_mode = 1'b0;  bus8.a_in = '0;  bus8.b_in = '0;
        bus16.start = 1'b0; bus16.signed_mode = 1'b0; bus16.a_in = '0; bus16.b_in = '0;
`ifdef BOOTH_ABORT_EN
        bus8.abort = 1'b0;
        bus16.abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_product8", {16'b0, bus8.product}, 32'h0);
        check("reset_busy8", 32'(bus8.busy), 32'd0);
        check("reset_done8", 32'(bus8.done), 32'd0);
        check("reset_product16", bus16.product, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unsigned maximum operands
        drive(0, 16'd255, 16'd255, 0, 32'h0000_FE01, 1, 0);
        check("start_busy8", 32'(bus8.busy), 32'd1);
        await_done(0, 6, 1, "u255x255");

        // Signed corners and an unsigned 0x80
        drive(0, 16'h0080, 16'h0080, 1, 32'h0000_4000, 1, 0);
        await_done(0, 6, 1, "s_m128xm128");
        drive(0, 16'h00FF, 16'h007F, 1, 32'h0000_FF81, 1, 0);
        await_done(0, 6, 1, "s_m1x127");
        drive(0, 16'h0080, 16'h0001, 0, 32'h0000_0080, 1, 0);
        await_done(0, 6, 1, "u128x1");

        // Back-to-back with start held high
        drive(0, 16'd3, 16'd5, 0, 32'd15, 1, 1);
        bus8.a_in = 8'd7; bus8.b_in = 8'd9; bus8.signed_mode = 1'b0;
        sb.push_back(32'd63);
        await_done(0, 6, 0, "b2b_first");
        @(posedge clk); #1;
        check("b2b_reaccept_busy", 32'(bus8.busy), 32'd1);
        await_done(0, 6, 0, "b2b_second");
        bus8.start = 1'b0;
        @(posedge clk); #1;
        check("b2b_done_single_pulse", 32'(bus8.done), 32'd0);

        // Reset three cycles into CALC
        drive(0, 16'd100, 16'd100, 0, 32'd0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midreset_product", {16'b0, bus8.product}, 32'h0);
        check("midreset_busy", 32'(bus8.busy), 32'd0);
        check("midreset_done", 32'(bus8.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        no_done_for(0, 10, "midreset_no_done");
        drive(0, 16'd2, 16'd3, 0, 32'd6, 1, 0);
        await_done(0, 6, 1, "after_reset_2x3");

        // WIDTH=16 corners
        drive(1, 16'hFFFF, 16'hFFFF, 0, 32'hFFFE_0001, 1, 0);
        await_done(1, 10, 1, "w16_uFFFFxFFFF");
        drive(1, 16'h8000, 16'h7FFF, 1, 32'hC000_8000, 1, 0);
        await_done(1, 10, 1, "w16_s8000x7FFF");

        // Random operands against the model
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            drive(0, ra, rb, rs, model(0, ra, rb, rs), 1, 0);
            await_done(0, 6, 0, "rand8");
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            drive(1, ra, rb, rs, model(1, ra, rb, rs), 1, 0);
            await_done(1, 10, 0, "rand16");
        end

`ifdef BOOTH_ABORT_EN
        drive(0, 16'd5, 16'd5, 0, 32'd25, 1, 0);
        await_done(0, 6, 1, "pre_abort_5x5");
        drive(0, 16'h55, 16'h33, 0, 32'd0, 0, 0);
        @(posedge clk); #1;
        bus8.abort = 1'b1;
        @(posedge clk); #1;
        bus8.abort = 1'b0;
        check("abort_busy", 32'(bus8.busy), 32'd0);
        check("abort_done", 32'(bus8.done), 32'd0);
        check("abort_product_kept", {16'b0, bus8.product}, 32'd25);
        no_done_for(0, 10, "abort_no_done");
        // Abort together with start in IDLE: start wins
        bus8.abort = 1'b1;
        drive(0, 16'd12, 16'd12, 0, 32'd144, 1, 0);
        bus8.abort = 1'b0;
        await_done(0, 6, 1, "post_abort_12x12");
`endif

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
